alsu_result_buffer: RTL and testbench
=====================================

Name: alsu_result_buffer

Overview:
Downstream stage of the ALSU. Aligns each issued ALSU operation with its registered result, which appears 2 cycles after issue. It tags the result with opcode and an invalid flag and queues the entry in a show-ahead FIFO drained through a valid/ready handshake. It also keeps saturating statistics: dropped entries and invalid operations.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >=2
LATENCY, 2, cycles from ALSU input sample to valid ALSU out; >=1
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
issue_valid  in  1  an operation is presented to the ALSU this cycle
issue_opcode  in  3  opcode presented to the ALSU
issue_red_op_A  in  1  red_op_A presented to the ALSU
issue_red_op_B  in  1  red_op_B presented to the ALSU
alsu_out  in  6  ALSU out, signed
clear_stats  in  1  synchronous clear of the counters and overflow
res_valid  out  1  FIFO head is valid
res_ready  in  1  consumer accepts the head
res_data  out  6  captured alsu_out, signed
res_opcode  out  3  opcode of the head entry
res_invalid  out  1  head entry came from an invalid operation
fifo_full  out  1  level == DEPTH
fifo_empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  current occupancy
drop_cnt  out  CNT_W  entries lost on a full FIFO, saturating
err_cnt  out  CNT_W  invalid operations enqueued, saturating
overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset (rst=0, async), all of the following clear to 0:
  - latency pipe and FIFO pointers
  - level, drop_cnt, err_cnt, overflow
  - res_valid=0, fifo_empty=1, fifo_full=0
  - res_data, res_opcode and res_invalid read 0
- Reset mid-operation discards all in-flight and queued entries. On release, the first push occurs no earlier than LATENCY cycles after the first issue_valid.
- Invalid detection at issue:
  - inv = ((red_op_A|red_op_B) & (opcode[1]|opcode[2])) | (opcode[1]&opcode[2])
- Latency pipe:
  - LATENCY register stages carry {valid, opcode, inv}.
  - push = valid at stage LATENCY.
  - On the same edge, the entry stored is {alsu_out, opcode, inv}.
  - issue_valid asserted for N consecutive cycles yields N consecutive pushes, starting LATENCY cycles later. Gaps are preserved.
- FIFO behaviour:
  - Show-ahead: res_data/res_opcode/res_invalid reflect mem[rd_ptr] whenever res_valid=1.
  - res_valid = !fifo_empty. There is no same-cycle fall-through: an entry pushed at edge k is visible after edge k.
  - pop = res_valid & res_ready. While res_valid=1 and res_ready=0, outputs hold stable.
  - Pointers wrap modulo DEPTH; level is kept as an explicit counter.
  - Push and pop in the same cycle: level unchanged. This is legal when full, since the pop frees a slot and the push is accepted (no drop).
  - Push when full and no pop: entry discarded, drop_cnt+1 (saturating at all-ones), overflow set.
  - Pop when empty: impossible (res_valid=0); pointers do not move.
- Statistics:
  - err_cnt increments, saturating, on each accepted push with inv=1. Dropped invalid entries count only in drop_cnt.
  - clear_stats=1 zeroes drop_cnt, err_cnt and overflow on the next edge. Clear wins over a same-cycle increment. FIFO contents are unaffected.
- All outputs except res_data/res_opcode/res_invalid are registered.

Optional Feature:
ALSU_RESULT_PARITY_EN
- Defined: each entry stores a parity bit = ^{inv, opcode, alsu_out} computed at push. An extra output port res_parity (1 bit) presents the head entry's stored bit, with the same show-ahead timing. It reads 0 after reset.
- Undefined: no parity storage, and the res_parity port does not exist.

Test Plan:
1. Latency alignment: reset; issue_valid=1 for one cycle with opcode=2; alsu_out=6'sd5 two cycles later -> res_valid rises after that edge; res_data=5, res_opcode=2, res_invalid=0, level=1.
2. Invalid tagging: issue opcode=3, red_op_A=1, alsu_out=0 at stage 2 -> res_invalid=1, err_cnt=1. Issue opcode=6 -> err_cnt=2.
3. Fill and drop: res_ready=0; 10 back-to-back issues with alsu_out=1..10 -> level=8, fifo_full=1, drop_cnt=2, overflow=1. Draining yields data 1..8 in order, then fifo_empty=1.
4. Full with simultaneous push/pop: FIFO full, res_ready=1, continuous issues -> drop_cnt stays 0, level stays 8, order preserved.
5. Backpressure and wrap: alternate res_ready 1/0 over 20 issues -> outputs stable while stalled, pointers wrap, all 20 results received in order.
6. Reset and clear: assert rst low with level=5, mid-pipe -> all outputs 0, fifo_empty=1 immediately. Separately, clear_stats with a same-cycle drop -> drop_cnt=0, overflow=0.

Source files
------------

// File: rtl/alsu_result_buffer.sv
// alsu_result_buffer: downstream stage of the ALSU.
// Aligns each issued operation with its registered ALSU result (LATENCY cycles
// later), tags it with opcode and an invalid flag, and queues it in a
// show-ahead FIFO drained by a valid/ready handshake. Keeps saturating
// statistics for dropped entries and enqueued invalid operations.
// Optional feature: define ALSU_RESULT_PARITY_EN to store a per-entry parity
// bit and expose it on res_parity.
module alsu_result_buffer #(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [2:0]               issue_opcode,
    input  logic                     issue_red_op_A,
    input  logic                     issue_red_op_B,
    input  logic signed [5:0]        alsu_out,
    input  logic                     clear_stats,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [5:0]        res_data,
    output logic [2:0]               res_opcode,
    output logic                     res_invalid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         err_cnt,
`ifdef ALSU_RESULT_PARITY_EN
    output logic                     overflow,
    output logic                     res_parity
`else
    output logic                     overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Latency pipe carrying the issue-side tag until the result is valid.
    logic [LATENCY-1:0] pipe_valid;
    logic [2:0]         pipe_opcode [LATENCY];
    logic               pipe_inv    [LATENCY];

    // FIFO storage and control.
    logic [5:0]         mem_data   [DEPTH];
    logic [2:0]         mem_opcode [DEPTH];
    logic               mem_inv    [DEPTH];
`ifdef ALSU_RESULT_PARITY_EN
    logic               mem_par    [DEPTH];
`endif
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_next;

    logic issue_inv;
    logic push;
    logic pop;
    logic push_accept;
    logic push_drop;

    // An operation is invalid when a reduction is requested on a non-bitwise
    // opcode, or when the opcode is one of the two reserved encodings.
    assign issue_inv = ((issue_red_op_A | issue_red_op_B) & (issue_opcode[1] | issue_opcode[2]))
                     | (issue_opcode[1] & issue_opcode[2]);

    assign push        = pipe_valid[LATENCY-1];
    assign res_valid   = ~fifo_empty;
    assign pop         = res_valid & res_ready;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push_accept = push & (~fifo_full | pop);
    assign push_drop   = push & fifo_full & ~pop;

    // Shift the issue tag through LATENCY register stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_opcode[i] <= '0;
                pipe_inv[i]    <= 1'b0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
            pipe_valid[0]  <= issue_valid;
            pipe_opcode[0] <= issue_opcode;
            pipe_inv[0]    <= issue_inv;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i]  <= pipe_valid[i-1];
                pipe_opcode[i] <= pipe_opcode[i-1];
                pipe_inv[i]    <= pipe_inv[i-1];
            end
        end
    end

    // Write an accepted entry into the storage array.
    // NOTE: the storage array has no reset; outputs are gated by res_valid so stale contents never show.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem_data[wr_ptr]   <= alsu_out;
            mem_opcode[wr_ptr] <= pipe_opcode[LATENCY-1];
            mem_inv[wr_ptr]    <= pipe_inv[LATENCY-1];
`ifdef ALSU_RESULT_PARITY_EN
            mem_par[wr_ptr]    <= ^{pipe_inv[LATENCY-1], pipe_opcode[LATENCY-1], alsu_out};
`endif
        end
    end

    // Next occupancy from the accepted push and the pop.
    always_comb begin
        // NOTE: default first so every path assigns level_next and no latch is inferred.
        level_next = level;
        if (push_accept && !pop) begin
            level_next = level + LVL_W'(1);
        end else if (!push_accept && pop) begin
            level_next = level - LVL_W'(1);
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push_accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)         rd_ptr <= rd_ptr + PTR_W'(1);
            level      <= level_next;
            fifo_full  <= (level_next == LVL_W'(DEPTH));
            fifo_empty <= (level_next == '0);
        end
    end

    // Saturating statistics; clear_stats overrides any same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear_stats) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (push_accept && pipe_inv[LATENCY-1] && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    // Show-ahead head of the FIFO; reads zero while empty.
    assign res_data    = res_valid ? mem_data[rd_ptr]   : '0;
    assign res_opcode  = res_valid ? mem_opcode[rd_ptr] : '0;
    assign res_invalid = res_valid ? mem_inv[rd_ptr]    : 1'b0;
`ifdef ALSU_RESULT_PARITY_EN
    assign res_parity  = res_valid ? mem_par[rd_ptr]    : 1'b0;
`endif

endmodule

// File: tb/tb_alsu_result_buffer.sv
// Self-checking bench for alsu_result_buffer: a queue-based reference model
// updated on every clock edge, a negedge compare process, and directed
// scenarios with hand-computed literal expectations.
module tb_alsu_result_buffer;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam int CNT_W = 8;
    localparam int HIST  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              issue_valid = 1'b0;
    logic [2:0]        issue_opcode = '0;
    logic              issue_red_op_A = 1'b0;
    logic              issue_red_op_B = 1'b0;
    logic signed [5:0] alsu_out = '0;
    logic              clear_stats = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic signed [5:0] res_data;
    logic [2:0]        res_opcode;
    logic              res_invalid;
    logic              fifo_full;
    logic              fifo_empty;
    logic [3:0]        level;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              overflow;
`ifdef ALSU_RESULT_PARITY_EN
    logic              res_parity;
`endif

    alsu_result_buffer #(.DEPTH(DEPTH), .LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_red_op_A(issue_red_op_A), .issue_red_op_B(issue_red_op_B),
        .alsu_out(alsu_out), .clear_stats(clear_stats),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_opcode(res_opcode), .res_invalid(res_invalid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt),
`ifdef ALSU_RESULT_PARITY_EN
        .overflow(overflow), .res_parity(res_parity)
`else
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0] data;
        logic [2:0] op;
        logic       inv;
    } ent_t;

    ent_t       q[$];
    int         m_drop = 0;
    int         m_err  = 0;
    bit         m_ovf  = 0;
    int         mcyc   = 0;
    bit         hv   [HIST];
    logic [2:0] hop  [HIST];
    bit         hinv [HIST];
    bit         m_pop;
    ent_t       m_ent;

    // Reserved opcodes 6/7 are always invalid; reductions are only legal on opcodes 0/1.
    function automatic bit is_invalid(input logic [2:0] op, input logic ra, input logic rb);
        if (op >= 3'd6) return 1'b1;
        if (op >= 3'd2 && (ra || rb)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_drop = 0;
            m_err  = 0;
            m_ovf  = 0;
            mcyc   = 0;
            for (int i = 0; i < HIST; i++) hv[i] = 0;
        end else begin
            m_pop = (q.size() > 0) && res_ready;
            if (m_pop) void'(q.pop_front());
            if (mcyc >= LAT && hv[mcyc-LAT]) begin
                m_ent.data = alsu_out;
                m_ent.op   = hop[mcyc-LAT];
                m_ent.inv  = hinv[mcyc-LAT];
                if (q.size() < DEPTH) begin
                    q.push_back(m_ent);
                    if (m_ent.inv && m_err < 255) m_err++;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end
            end
            if (clear_stats) begin
                m_drop = 0;
                m_err  = 0;
                m_ovf  = 0;
            end
            if (mcyc < HIST) begin
                hv[mcyc]   = issue_valid;
                hop[mcyc]  = issue_opcode;
                hinv[mcyc] = is_invalid(issue_opcode, issue_red_op_A, issue_red_op_B);
                mcyc++;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [5:0] rx [64];
    int         rx_n = 0;
    bit         stall_prev = 0;
    logic [5:0] stall_data;

    always @(negedge clk) begin
        check("res_valid", res_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("res_data", {26'b0, res_data}, q[0].data);
            check("res_opcode", res_opcode, q[0].op);
            check("res_invalid", res_invalid, q[0].inv);
`ifdef ALSU_RESULT_PARITY_EN
            check("res_parity", res_parity, ^{q[0].inv, q[0].op, q[0].data});
`endif
        end else begin
            check("res_data_idle", {26'b0, res_data}, 0);
            check("res_opcode_idle", res_opcode, 0);
            check("res_invalid_idle", res_invalid, 0);
        end
        check("level", level, q.size());
        check("fifo_full", fifo_full, q.size() == DEPTH);
        check("fifo_empty", fifo_empty, q.size() == 0);
        check("drop_cnt", drop_cnt, m_drop);
        check("err_cnt", err_cnt, m_err);
        check("overflow", overflow, m_ovf);
        if (stall_prev && res_valid) check("stall_hold", {26'b0, res_data}, stall_data);
        stall_prev = res_valid && !res_ready;
        stall_data = res_data;
        if (res_valid && res_ready && rx_n < 64) begin
            rx[rx_n] = res_data;
            rx_n++;
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] plan [HIST];
    int         tcyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        issue_valid    = 1'b0;
        issue_opcode   = '0;
        issue_red_op_A = 1'b0;
        issue_red_op_B = 1'b0;
        clear_stats    = 1'b0;
        alsu_out       = plan[tcyc];
    endtask

    task automatic issue(input logic [2:0] op, input logic ra, input logic rb, input logic [5:0] val);
        issue_valid    = 1'b1;
        issue_opcode   = op;
        issue_red_op_A = ra;
        issue_red_op_B = rb;
        plan[tcyc+LAT] = val;
    endtask

    initial begin
        for (int i = 0; i < HIST; i++) plan[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_level", level, 0);
        rst = 1'b1;
        tick();

        // 1. latency alignment
        issue(3'd2, 0, 0, 6'd5);
        tick();
        tick();
        check("t1_not_early", res_valid, 0);
        tick();
        check("t1_valid", res_valid, 1);
        check("t1_data", {26'b0, res_data}, 5);
        check("t1_opcode", res_opcode, 2);
        check("t1_invalid", res_invalid, 0);
        check("t1_level", level, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 2. invalid tagging
        issue(3'd3, 1, 0, 6'd0);
        repeat (3) tick();
        check("t2_invalid", res_invalid, 1);
        check("t2_err1", err_cnt, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        issue(3'd6, 0, 0, 6'h3B);
        repeat (3) tick();
        check("t2_err2", err_cnt, 2);
        check("t2_neg_data", {26'b0, res_data}, 6'h3B);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 3. fill and drop
        for (int i = 1; i <= 10; i++) begin
            issue(3'd1, 0, 0, 6'(i));
            tick();
        end
        repeat (2) tick();
        check("t3_level", level, 8);
        check("t3_full", fifo_full, 1);
        check("t3_drop", drop_cnt, 2);
        check("t3_ovf", overflow, 1);
        rx_n = 0;
        res_ready = 1'b1;
        repeat (10) tick();
        res_ready = 1'b0;
        check("t3_rx_count", rx_n, 8);
        for (int k = 0; k < 8; k++) check("t3_order", {26'b0, rx[k]}, k + 1);
        check("t3_empty", fifo_empty, 1);

        // 4. full with simultaneous push/pop
        clear_stats = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            issue(3'd0, 0, 0, 6'(11 + i));
            tick();
        end
        repeat (2) tick();
        check("t4_full", fifo_full, 1);
        rx_n = 0;
        for (int k = 0; k < 10; k++) begin
            issue(3'd4, 0, 0, 6'(21 + k));
            if (k == 2) res_ready = 1'b1;
            tick();
            check("t4_level", level, 8);
        end
        repeat (25) tick();
        res_ready = 1'b0;
        check("t4_drop", drop_cnt, 0);
        check("t4_rx_count", rx_n, 18);
        for (int k = 0; k < 18; k++)
            check("t4_order", {26'b0, rx[k]}, (k < 8) ? 11 + k : 21 + k - 8);

        // 5. backpressure and wrap
        rx_n = 0;
        for (int k = 0; k < 20; k++) begin
            issue(3'(k % 8), 1'(k % 2), 1'b0, 6'(k + 1));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            tick();
        end
        for (int k = 0; k < 30; k++) begin
            res_ready = 1'(k % 2);
            tick();
        end
        res_ready = 1'b0;
        check("t5_rx_count", rx_n, 20);
        for (int k = 0; k < 20; k++) check("t5_order", {26'b0, rx[k]}, k + 1);

        // 6a. reset mid-operation
        for (int i = 0; i < 7; i++) begin
            issue(3'd1, 0, 0, 6'(40 + i));
            tick();
        end
        check("t6_level5", level, 5);
        #2 rst = 1'b0;
        #1;
        check("t6_valid", res_valid, 0);
        check("t6_empty", fifo_empty, 1);
        check("t6_full", fifo_full, 0);
        check("t6_level", level, 0);
        check("t6_data", {26'b0, res_data}, 0);
        check("t6_err", err_cnt, 0);
        check("t6_ovf", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) tick();
        check("t6_no_stale", level, 0);

        // 6b. clear with a same-cycle drop
        for (int i = 0; i < 9; i++) begin
            issue(3'd0, 0, 0, 6'(i));
            tick();
        end
        repeat (2) tick();
        check("t6b_drop1", drop_cnt, 1);
        issue(3'd0, 0, 0, 6'd9);
        tick();
        tick();
        clear_stats = 1'b1;
        tick();
        check("t6b_drop0", drop_cnt, 0);
        check("t6b_ovf0", overflow, 0);
        check("t6b_level", level, 8);

        res_ready = 1'b1;
        repeat (12) tick();
        check("final_empty", fifo_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
